// File: rtl/tile_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_dispatcher_if
// Purpose  : Command, solver and merged-result signals of the tile dispatcher.
// Revision : 1.0
// ============================================================================
interface tile_dispatcher_if #(
    parameter int NUM_SOLVERS    = 4,
    parameter int TILE_SIZE_BITS = 6,
    parameter int DATA_BITS      = 16
);
    localparam int c_AB = 2 * TILE_SIZE_BITS;
    localparam int c_SB = $clog2(NUM_SOLVERS);

    logic                            in_valid;
    logic                            in_ready;
    logic                            in_end_of_stream;
    logic [31:0]                     in_data;

    logic [NUM_SOLVERS-1:0]          sol_in_valid;
    logic [NUM_SOLVERS-1:0]          sol_in_end_of_stream;
    logic [31:0]                     sol_in_data;
    logic [NUM_SOLVERS-1:0]          sol_in_ready;

    logic [NUM_SOLVERS-1:0]          sol_out_valid;
    logic [NUM_SOLVERS*c_AB-1:0]     sol_out_addr;
    logic [NUM_SOLVERS*DATA_BITS-1:0] sol_out_data;
    logic [NUM_SOLVERS-1:0]          sol_out_ready;

    logic                            out_valid;
    logic                            out_ready;
    logic [c_AB-1:0]                 out_addr;
    logic [DATA_BITS-1:0]            out_data;
    logic [c_SB-1:0]                 out_solver;

    logic [NUM_SOLVERS-1:0]          busy;
    logic                            tile_done;
    logic [c_SB-1:0]                 tile_done_solver;

    // Dispatcher side
    modport slave (
        input  in_valid, in_end_of_stream, in_data,
        input  sol_in_ready,
        input  sol_out_valid, sol_out_addr, sol_out_data,
        input  out_ready,
        output in_ready,
        output sol_in_valid, sol_in_end_of_stream, sol_in_data,
        output sol_out_ready,
        output out_valid, out_addr, out_data, out_solver,
        output busy, tile_done, tile_done_solver
    );

    // Environment side: upstream source, solvers and result sink
    modport master (
        output in_valid, in_end_of_stream, in_data,
        output sol_in_ready,
        output sol_out_valid, sol_out_addr, sol_out_data,
        output out_ready,
        input  in_ready,
        input  sol_in_valid, sol_in_end_of_stream, sol_in_data,
        input  sol_out_ready,
        input  out_valid, out_addr, out_data, out_solver,
        input  busy, tile_done, tile_done_solver
    );
endinterface

`default_nettype wire

// File: rtl/tile_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tile_dispatcher
// Purpose  : Routes command tiles round-robin to free solvers and merges their
//            pixel results into one registered stream. Optional statistics
//            counters are built when TILE_DISPATCHER_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module tile_dispatcher #(
    parameter int NUM_SOLVERS    = 4,
    parameter int TILE_SIZE_BITS = 6,
    parameter int DATA_BITS      = 16
) (
    input  wire             clk,
    input  wire             rst,
    tile_dispatcher_if.slave bus
`ifdef TILE_DISPATCHER_STATS_EN
    ,
    output logic [31:0]     tiles_dispatched,
    output logic [31:0]     pixels_emitted
`endif
);
    localparam int              c_AB       = 2 * TILE_SIZE_BITS;
    localparam int              c_SB       = $clog2(NUM_SOLVERS);
    localparam logic [c_AB-1:0] c_PIX_LAST = {c_AB{1'b1}};

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_SB-1:0]        r_sel;
    logic [c_SB-1:0]        w_sel_nxt;
    logic [c_SB-1:0]        r_rr_ptr;
    logic [c_SB-1:0]        r_out_ptr;
    logic [NUM_SOLVERS-1:0] r_busy;
    logic [NUM_SOLVERS-1:0] w_busy_set;
    logic [NUM_SOLVERS-1:0] w_busy_clr;
    logic [c_AB-1:0]        r_pix_cnt [NUM_SOLVERS];

    logic                   w_free_found;
    logic [c_SB-1:0]        w_free_idx;
    logic                   w_tile_end;
    logic                   w_load;
    logic                   w_grant_found;
    logic [c_SB-1:0]        w_grant_idx;
    logic                   w_grant;
    logic                   w_pix_wrap;

    logic                   r_out_valid;
    logic [c_AB-1:0]        r_out_addr;
    logic [DATA_BITS-1:0]   r_out_data;
    logic [c_SB-1:0]        r_out_solver;
    logic                   r_tile_done;
    logic [c_SB-1:0]        r_tile_done_solver;

    // First set bit of vec at or after start, wrapping; MSB of result = found.
    function automatic logic [c_SB:0] first_set(input logic [NUM_SOLVERS-1:0] vec,
                                                input logic [c_SB-1:0]        start);
        logic [c_SB:0]   res;
        logic [c_SB-1:0] idx;
        res = '0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            idx = start + c_SB'(k);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Selection uses the registered busy vector, so a solver freed this cycle
    // becomes eligible only on the following cycle.
    assign {w_free_found, w_free_idx}   = first_set(~r_busy, r_rr_ptr);
    assign {w_grant_found, w_grant_idx} = first_set(bus.sol_out_valid, r_out_ptr);

    assign w_load     = !r_out_valid || bus.out_ready;
    assign w_grant    = w_load && w_grant_found && !rst;
    assign w_pix_wrap = w_grant && (r_pix_cnt[w_grant_idx] == c_PIX_LAST);

    always_comb begin
        w_state_nxt               = r_state;
        w_sel_nxt                 = r_sel;
        w_tile_end                = 1'b0;
        bus.in_ready              = 1'b0;
        bus.sol_in_valid          = '0;
        bus.sol_in_end_of_stream  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_free_found) begin
                    w_sel_nxt   = w_free_idx;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!rst) begin
                    bus.sol_in_valid[r_sel]         = bus.in_valid;
                    bus.sol_in_end_of_stream[r_sel] = bus.in_end_of_stream;
                    bus.in_ready                    = bus.sol_in_ready[r_sel];
                    w_tile_end = bus.in_valid && bus.sol_in_ready[r_sel] && bus.in_end_of_stream;
                    if (w_tile_end) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.sol_in_data = bus.in_data;

    always_comb begin
        bus.sol_out_ready = '0;
        w_busy_set        = '0;
        w_busy_clr        = '0;
        if (w_grant) begin
            bus.sol_out_ready[w_grant_idx] = 1'b1;
        end
        if (w_tile_end) begin
            w_busy_set[r_sel] = 1'b1;
        end
        if (w_pix_wrap) begin
            w_busy_clr[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_sel              <= '0;
            r_rr_ptr           <= '0;
            r_out_ptr          <= '0;
            r_busy             <= '0;
            r_out_valid        <= 1'b0;
            r_out_addr         <= '0;
            r_out_data         <= '0;
            r_out_solver       <= '0;
            r_tile_done        <= 1'b0;
            r_tile_done_solver <= '0;
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                r_pix_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            // A new tile landing on a solver outranks a stray wrap of its counter
            r_busy      <= (r_busy & ~w_busy_clr) | w_busy_set;
            r_tile_done <= 1'b0;
            if (w_tile_end) begin
                r_rr_ptr <= r_sel + c_SB'(1);
            end
            if (w_load) begin
                r_out_valid <= w_grant;
            end
            if (w_grant) begin
                r_out_addr   <= bus.sol_out_addr[w_grant_idx*c_AB +: c_AB];
                r_out_data   <= bus.sol_out_data[w_grant_idx*DATA_BITS +: DATA_BITS];
                r_out_solver <= w_grant_idx;
                r_out_ptr    <= w_grant_idx + c_SB'(1);
                if (w_pix_wrap) begin
                    r_pix_cnt[w_grant_idx] <= '0;
                    r_tile_done            <= 1'b1;
                    r_tile_done_solver     <= w_grant_idx;
                end else begin
                    r_pix_cnt[w_grant_idx] <= r_pix_cnt[w_grant_idx] + c_AB'(1);
                end
            end
        end
    end

    assign bus.out_valid        = r_out_valid;
    assign bus.out_addr         = r_out_addr;
    assign bus.out_data         = r_out_data;
    assign bus.out_solver       = r_out_solver;
    assign bus.busy             = r_busy;
    assign bus.tile_done        = r_tile_done;
    assign bus.tile_done_solver = r_tile_done_solver;

`ifdef TILE_DISPATCHER_STATS_EN
    logic [31:0] r_tiles_dispatched;
    logic [31:0] r_pixels_emitted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tiles_dispatched <= '0;
            r_pixels_emitted   <= '0;
        end else begin
            if (w_tile_end) begin
                r_tiles_dispatched <= r_tiles_dispatched + 32'd1;
            end
            if (r_out_valid && bus.out_ready) begin
                r_pixels_emitted <= r_pixels_emitted + 32'd1;
            end
        end
    end

    assign tiles_dispatched = r_tiles_dispatched;
    assign pixels_emitted   = r_pixels_emitted;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: doc/tile_dispatcher.md
TILE_DISPATCHER -- requirements
Module: tile_dispatcher

Interface
REQ-001 Parameter NUM_SOLVERS, 4: number of attached tile solvers; power of two, 2..16.
REQ-002 Parameter TILE_SIZE_BITS, 6: tile edge is 2^TILE_SIZE_BITS pixels; pixels per tile P = 2^(2*TILE_SIZE_BITS).
REQ-003 Parameter DATA_BITS, 16: width of one pixel result (iteration count).
REQ-004 Derived: AB = 2*TILE_SIZE_BITS (pixel address width); SB = log2(NUM_SOLVERS).
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid / in_ready / in_end_of_stream  in/out/in  1 each  upstream command-word handshake; end_of_stream marks a tile's last word.
REQ-008 in_data  in  32  command word: type in [31:29], payload in [28:0]; forwarded unmodified.
REQ-009 sol_in_valid, sol_in_end_of_stream  out  NUM_SOLVERS  per-solver command valid and last-word flag.
REQ-010 sol_in_data  out  32  command word broadcast to all solvers.
REQ-011 sol_in_ready  in  NUM_SOLVERS  per-solver command ready.
REQ-012 sol_out_valid  in  NUM_SOLVERS; sol_out_addr  in  NUM_SOLVERS*AB; sol_out_data  in  NUM_SOLVERS*DATA_BITS; solver i occupies slice i.
REQ-013 sol_out_ready  out  NUM_SOLVERS  per-solver result ready.
REQ-014 out_valid / out_ready  out/in  1 each; out_addr  out  AB; out_data  out  DATA_BITS; out_solver  out  SB  merged result stream.
REQ-015 busy  out  NUM_SOLVERS  solver i holds an undrained tile.
REQ-016 tile_done  out  1; tile_done_solver  out  SB  one-cycle pulse when a solver's last pixel is accepted.

Function
REQ-017 Dispatch FSM states: IDLE, STREAM.
REQ-018 IDLE: in_ready=0; all sol_in_valid=0; if any busy bit clear, latch sel = first non-busy index at or after rr_ptr (circular) and enter STREAM next cycle; otherwise remain IDLE.
REQ-019 STREAM: combinational pass-through, sol_in_valid[sel]=in_valid, sol_in_end_of_stream[sel]=in_end_of_stream, in_ready=sol_in_ready[sel]; other solvers' valid=0.
REQ-020 Word accepted with in_end_of_stream=1 in STREAM: busy[sel] set, rr_ptr=(sel+1) mod NUM_SOLVERS, next state IDLE (one bubble cycle per tile).
REQ-021 Output arbiter: registered single-entry stage; loads when out_valid=0 or out_ready=1.
REQ-022 On load, grant = first asserted sol_out_valid at or after out_ptr (circular); sol_out_ready[grant]=1 that cycle only; others 0; out_ptr=(grant+1) mod NUM_SOLVERS.
REQ-023 Loaded stage presents granted addr, data, index on out_addr/out_data/out_solver with out_valid=1 next cycle; latency exactly 1 cycle.
REQ-024 out_valid=1 and out_ready=0: all outputs held stable, all sol_out_ready=0.
REQ-025 Per-solver pixel counter (AB bits) increments when that solver's result is granted; at P-1 it wraps to 0, clears busy[i], pulses tile_done with tile_done_solver=i next cycle.
REQ-026 Busy clear and IDLE selection in the same cycle: selection uses pre-clear busy; freed solver eligible next cycle.
REQ-027 Grants accepted regardless of busy state; a non-busy solver's results still count.

Reset
REQ-028 reset: FSM IDLE, sel=0, rr_ptr=0, out_ptr=0, busy=0, pixel counters=0, out_valid=0, out_addr=0, out_data=0, out_solver=0, tile_done=0, in_ready=0, all sol_in_valid=0, all sol_out_ready=0.
REQ-029 Reset mid-stream or mid-output discards the in-flight tile and held result; no partial completion reported.

Configuration
REQ-030 Macro TILE_DISPATCHER_STATS_EN defined: adds outputs tiles_dispatched (32) and pixels_emitted (32), incremented on REQ-020 events and on out_valid&&out_ready, wrapping, cleared by reset.
REQ-031 TILE_DISPATCHER_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Verification (NUM_SOLVERS=2, TILE_SIZE_BITS=2, P=16)
REQ-032 Reset, then 8 words (last with end_of_stream) -> first word in_ready low one cycle, words appear on sol_in_valid[0] only; busy=2'b01 after last word.
REQ-033 Second 8-word tile immediately -> routed to solver 1; busy=2'b11; third tile held with in_ready=0 until a solver frees.
REQ-034 Both solvers assert sol_out_valid continuously, out_ready=1 -> out_solver alternates 0,1,0,1; each pixel appears 1 cycle after its sol_out_ready.
REQ-035 Solver 0 delivers 16 pixels -> tile_done=1 with tile_done_solver=0 one cycle after 16th accept; busy[0]=0; pending third tile goes to solver 0.
REQ-036 out_ready=0 for 5 cycles with out_valid=1 -> out_addr/out_data/out_solver stable, sol_out_ready=0 throughout.
REQ-037 reset asserted mid-stream on word 4 -> next cycle busy=0, out_valid=0, in_ready=0; new tile restarts at solver 0.
